// File: rtl/cic_interp_pkg.sv
// Shared types and helpers for the CIC interpolator stages (comb, upsampler, integrator).
package cic_interp_pkg;

    localparam int WIDTH_DEF      = 16;
    localparam int RATE_WIDTH_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // A programmed rate of zero behaves as a rate of one (pass-through).
    function automatic logic [31:0] clamp_rate(input logic [31:0] rate);
        return (rate == 32'd0) ? 32'd1 : rate;
    endfunction

endpackage

// File: rtl/cic_interp_upsampler.sv
// Zero-stuffing rate expander: each accepted I/Q sample becomes R output slots,
// the sample followed by R-1 zeros, with back-to-back bursts and no bubble.
module cic_interp_upsampler
    import cic_interp_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int RATE_WIDTH = RATE_WIDTH_DEF
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [RATE_WIDTH-1:0] i_rate,
    input  logic [WIDTH-1:0]      i_inph_data,
    input  logic [WIDTH-1:0]      i_quad_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [WIDTH-1:0]      o_inph_data,
    output logic [WIDTH-1:0]      o_quad_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready
);

    state_t                state;
    state_t                state_next;
    logic [RATE_WIDTH-1:0] phase;
    logic [RATE_WIDTH-1:0] rate_eff;
    logic                  at_last;
    logic                  accept;
    logic                  consume;

    // rate_eff is never zero, so rate_eff-1 cannot wrap.
    assign at_last = (phase == (rate_eff - RATE_WIDTH'(1)));
    assign o_valid = (state == EMIT);
    assign o_last  = at_last && o_valid;
    assign consume = o_valid && i_ready;
    assign o_ready = !i_reset && ((state == IDLE) || (o_last && i_ready));
    assign accept  = i_valid && o_ready;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = EMIT;
        end else if (consume && at_last) begin
            state_next = IDLE;
        end
    end

    // The output registers double as the holding register: the sample is only
    // shown in phase 0, after which the slots are zero until the next accept.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            phase       <= '0;
            rate_eff    <= RATE_WIDTH'(1);
            o_inph_data <= '0;
            o_quad_data <= '0;
        end else if (accept) begin
            phase       <= '0;
            rate_eff    <= RATE_WIDTH'(clamp_rate(32'(i_rate)));
            o_inph_data <= i_inph_data;
            o_quad_data <= i_quad_data;
        end else if (consume) begin
            phase       <= at_last ? '0 : phase + RATE_WIDTH'(1);
            o_inph_data <= '0;
            o_quad_data <= '0;
        end
    end

endmodule

// File: tb/tb_cic_interp_upsampler.sv
// Directed bench for cic_interp_upsampler: burst shape, back-to-back, stalls,
// unity rate, mid-burst rate change and asynchronous reset abort.
module tb_cic_interp_upsampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rate = 8'd1;
    logic [15:0] in_i = '0;
    logic [15:0] in_q = '0;
    logic        in_valid = 1'b0;
    logic        out_ready;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_valid;
    logic        out_last;
    logic        ds_ready = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    cic_interp_upsampler #(.WIDTH(16), .RATE_WIDTH(8)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rate      (rate),
        .i_inph_data (in_i),
        .i_quad_data (in_q),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .o_inph_data (out_i),
        .o_quad_data (out_q),
        .o_valid     (out_valid),
        .o_last      (out_last),
        .i_ready     (ds_ready)
    );

    task automatic test_reset();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_ready !== 1'b0 ||
            out_i !== 16'h0 || out_q !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b last=%b ready=%b i=%h q=%h, want 0 0 0 0000 0000",
                     out_valid, out_last, out_ready, out_i, out_q);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: ready=%b valid=%b, want 1 0", out_ready, out_valid);
        end
    endtask

    task automatic test_single_r4();
        @(negedge clk);
        rate = 8'd4; in_i = 16'h1234; in_q = 16'hFEDC; in_valid = 1'b1; ds_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b1 || out_last !== (k == 3) ||
                out_i !== (k == 0 ? 16'h1234 : 16'h0) || out_q !== (k == 0 ? 16'hFEDC : 16'h0)) begin
                tests_failed++;
                $display("FAIL single_r4 slot %0d: valid=%b last=%b i=%h q=%h, want 1 %b %h %h", k,
                         out_valid, out_last, out_i, out_q, (k == 3),
                         (k == 0 ? 16'h1234 : 16'h0), (k == 0 ? 16'hFEDC : 16'h0));
            end
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || out_i !== 16'h0 || out_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_r4 idle: valid=%b i=%h ready=%b, want 0 0000 1", out_valid, out_i, out_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] smp [3];
        smp[0] = 16'h1111; smp[1] = 16'h2222; smp[2] = 16'h3333;
        @(negedge clk);
        rate = 8'd4; in_i = smp[0]; in_q = ~smp[0]; in_valid = 1'b1; ds_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                tests_run++;
                if (out_valid !== 1'b1 || out_last !== (k == 3) || out_ready !== (k == 3) ||
                    out_i !== (k == 0 ? smp[s] : 16'h0) || out_q !== (k == 0 ? ~smp[s] : 16'h0)) begin
                    tests_failed++;
                    $display("FAIL back_to_back s%0d k%0d: valid=%b last=%b ready=%b i=%h q=%h, want 1 %b %b %h %h",
                             s, k, out_valid, out_last, out_ready, out_i, out_q, (k == 3), (k == 3),
                             (k == 0 ? smp[s] : 16'h0), (k == 0 ? ~smp[s] : 16'h0));
                end
                if (k == 3) begin
                    if (s < 2) begin
                        in_i = smp[s+1]; in_q = ~smp[s+1];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL back_to_back end: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_stall();
        int ph;
        int consumed;
        ph = 0; consumed = 0;
        @(negedge clk);
        rate = 8'd3; in_i = 16'h0100; in_q = 16'h0F00; in_valid = 1'b1; ds_ready = 1'b1;
        for (int c = 0; c < 30 && consumed < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            tests_run++;
            if (out_valid !== 1'b1 || out_last !== (ph == 2) ||
                out_i !== (ph == 0 ? 16'h0100 : 16'h0) || out_q !== (ph == 0 ? 16'h0F00 : 16'h0)) begin
                tests_failed++;
                $display("FAIL stall c%0d phase %0d: valid=%b last=%b i=%h q=%h, want 1 %b %h %h", c, ph,
                         out_valid, out_last, out_i, out_q, (ph == 2),
                         (ph == 0 ? 16'h0100 : 16'h0), (ph == 0 ? 16'h0F00 : 16'h0));
            end
            ds_ready = (c % 3 == 0);
            if (ds_ready) begin
                consumed++;
                ph++;
            end
        end
        @(negedge clk);
        ds_ready = 1'b1;
        tests_run++;
        if (consumed != 3 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall end: consumed=%0d valid=%b, want 3 0", consumed, out_valid);
        end
    endtask

    task automatic test_unity(input logic [7:0] r);
        logic [15:0] smp [3];
        smp[0] = 16'hA5A5; smp[1] = 16'h5A5A; smp[2] = 16'h8001;
        @(negedge clk);
        rate = r; in_i = smp[0]; in_q = smp[2]; in_valid = 1'b1; ds_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_last !== 1'b1 || out_ready !== 1'b1 ||
                out_i !== smp[k] || out_q !== smp[2-k]) begin
                tests_failed++;
                $display("FAIL unity r=%0d k%0d: valid=%b last=%b ready=%b i=%h q=%h, want 1 1 1 %h %h",
                         r, k, out_valid, out_last, out_ready, out_i, out_q, smp[k], smp[2-k]);
            end
            if (k < 2) begin
                in_i = smp[k+1]; in_q = smp[1-k];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL unity r=%0d end: valid=%b, want 0", r, out_valid);
        end
    endtask

    task automatic test_rate_change();
        int n;
        bit done;
        n = 0; done = 0;
        @(negedge clk);
        rate = 8'd8; in_i = 16'h0777; in_q = 16'h0888; in_valid = 1'b1; ds_ready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                n++;
                if (n == 4) rate = 8'd2;
                if (out_last) done = 1;
            end
        end
        tests_run++;
        if (n != 8 || !done) begin
            tests_failed++;
            $display("FAIL rate_change first burst: slots=%0d done=%0d, want 8 1", n, done);
        end
        n = 0; done = 0;
        @(negedge clk);
        in_i = 16'h0999; in_valid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                n++;
                if (out_last) done = 1;
            end
        end
        tests_run++;
        if (n != 2 || !done) begin
            tests_failed++;
            $display("FAIL rate_change second burst: slots=%0d done=%0d, want 2 1", n, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int n;
        bit done;
        @(negedge clk);
        rate = 8'd5; in_i = 16'h7FFF; in_q = 16'h8000; in_valid = 1'b1; ds_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_last !== 1'b0 || out_i !== 16'h0) begin
            tests_failed++;
            $display("FAIL abort pre: valid=%b last=%b i=%h, want 1 0 0000", out_valid, out_last, out_i);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_ready !== 1'b0 ||
            out_i !== 16'h0 || out_q !== 16'h0) begin
            tests_failed++;
            $display("FAIL abort async: valid=%b last=%b ready=%b i=%h q=%h, want 0 0 0 0000 0000",
                     out_valid, out_last, out_ready, out_i, out_q);
        end
        @(negedge clk);
        rst = 1'b0;
        in_i = 16'h0042; in_q = 16'hFFBE; in_valid = 1'b1;
        n = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid) begin
                n++;
                if (n == 1) begin
                    tests_run++;
                    if (out_i !== 16'h0042 || out_q !== 16'hFFBE || out_last !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL abort restart first slot: i=%h q=%h last=%b, want 0042 ffbe 0",
                                 out_i, out_q, out_last);
                    end
                end
                if (out_last) done = 1;
            end
        end
        tests_run++;
        if (n != 5 || !done) begin
            tests_failed++;
            $display("FAIL abort restart burst: slots=%0d done=%0d, want 5 1", n, done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_r4();
        test_back_to_back();
        test_stall();
        test_unity(8'd0);
        test_unity(8'd1);
        test_rate_change();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
